// File: rtl/fa_pipe_pkg.sv
// Shared types and helpers for the pipelined WIDTH-bit adder fa_pipe.
// Build option: FA_PIPE_OVF_EN adds the signed-overflow output.
package fa_pipe_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  // Bits of carry chain handled by each pipeline stage.
  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Per-stage control word travelling alongside the operand/sum skew registers.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

endpackage

// File: rtl/fa_slice.sv
// Combinational ripple adder for one pipeline slice, built from full-adder cells.
// Exposes the carry into the slice MSB so the last stage can derive signed overflow.
module fa_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         msb_cin
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_cell
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout    = c[W];
  assign msb_cin = c[W - 1];

endmodule

// File: rtl/fa_pipe.sv
// Pipelined a + b + cin over WIDTH bits, carry chain cut into STAGES registered slices.
// Valid/ready at both ends; FA_PIPE_OVF_EN adds the registered signed-overflow output ovf.
module fa_pipe
  import fa_pipe_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef FA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SLICE = slice_w(WIDTH, STAGES);

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_cfg_err
    $error("fa_pipe: WIDTH (%0d) must be a multiple of STAGES (%0d), 1 <= STAGES <= WIDTH",
           WIDTH, STAGES);
  end

  logic advance;

  // The whole pipe moves as one shift register; bubbles shift like data.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int DW = (k + 1) * SLICE;
    localparam int RW = WIDTH - DW;

    logic             vin;
    logic             cin_s;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] s_sl;
    logic             c_out;
    logic             msb_c;
    logic [DW-1:0]    done_nx;
    stage_ctl_t       ctl_r;
    logic [DW-1:0]    done_r;

    if (k == 0) begin : g_src
      assign vin     = in_valid;
      assign cin_s   = cin;
      assign a_sl    = a[SLICE-1:0];
      assign b_sl    = b[SLICE-1:0];
      assign done_nx = s_sl;
    end else begin : g_src
      assign vin     = g_st[k-1].ctl_r.valid;
      assign cin_s   = g_st[k-1].ctl_r.carry;
      assign a_sl    = g_st[k-1].g_rem.a_rem_r[SLICE-1:0];
      assign b_sl    = g_st[k-1].g_rem.b_rem_r[SLICE-1:0];
      assign done_nx = {s_sl, g_st[k-1].done_r};
    end

    fa_slice #(.W(SLICE)) u_slice (
      .a       (a_sl),
      .b       (b_sl),
      .cin     (cin_s),
      .sum     (s_sl),
      .cout    (c_out),
      .msb_cin (msb_c)
    );

    // Stage k: valid, carry into slice k+1 and the finished low sum bits.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ctl_r  <= '{valid: 1'b0, carry: 1'b0};
        done_r <= '0;
      end else if (advance) begin
        ctl_r  <= '{valid: vin, carry: c_out};
        done_r <= done_nx;
      end
    end

    // Operand slices not yet added ride along until their stage.
    if (k < STAGES - 1) begin : g_rem
      logic [RW-1:0] a_rem_r;
      logic [RW-1:0] b_rem_r;
      logic [RW-1:0] a_nx;
      logic [RW-1:0] b_nx;

      if (k == 0) begin : g_rsrc
        assign a_nx = a[WIDTH-1:SLICE];
        assign b_nx = b[WIDTH-1:SLICE];
      end else begin : g_rsrc
        assign a_nx = g_st[k-1].g_rem.a_rem_r[WIDTH-k*SLICE-1:SLICE];
        assign b_nx = g_st[k-1].g_rem.b_rem_r[WIDTH-k*SLICE-1:SLICE];
      end

      // Skew registers for the upper operand bits.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_rem_r <= '0;
          b_rem_r <= '0;
        end else if (advance) begin
          a_rem_r <= a_nx;
          b_rem_r <= b_nx;
        end
      end
    end

`ifdef FA_PIPE_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_r;

      // Signed overflow: carry into MSB differs from carry out of MSB.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (advance) begin
          ovf_r <= msb_c ^ c_out;
        end
      end
    end
`endif
  end

  assign out_valid = g_st[STAGES-1].ctl_r.valid;
  assign cout      = g_st[STAGES-1].ctl_r.carry;
  assign sum       = g_st[STAGES-1].done_r;
`ifdef FA_PIPE_OVF_EN
  assign ovf       = g_st[STAGES-1].g_ovf.ovf_r;
`endif

endmodule

// File: tb/tb_fa_pipe.sv
// Directed self-checking bench for fa_pipe (32/4 main instance, plus 8/1 and 8/8 instances).
// Define FA_PIPE_OVF_EN to also exercise the overflow output.
module tb_fa_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, cin, cout;
  logic [31:0] a, b, sum;

  logic        s_in_valid, s_out_ready, s_cin;
  logic [7:0]  s_a, s_b;
  logic        r1_in_ready, r1_out_valid, r1_cout;
  logic [7:0]  r1_sum;
  logic        r8_in_ready, r8_out_valid, r8_cout;
  logic [7:0]  r8_sum;
`ifdef FA_PIPE_OVF_EN
  logic        ovf, r1_ovf, r8_ovf;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fa_pipe #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef FA_PIPE_OVF_EN
    , .ovf(ovf)
`endif
  );

  fa_pipe #(.WIDTH(8), .STAGES(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(r1_in_ready), .a(s_a), .b(s_b),
    .cin(s_cin), .out_valid(r1_out_valid), .out_ready(s_out_ready), .sum(r1_sum), .cout(r1_cout)
`ifdef FA_PIPE_OVF_EN
    , .ovf(r1_ovf)
`endif
  );

  fa_pipe #(.WIDTH(8), .STAGES(8)) dut_s8 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(r8_in_ready), .a(s_a), .b(s_b),
    .cin(s_cin), .out_valid(r8_out_valid), .out_ready(s_out_ready), .sum(r8_sum), .cout(r8_cout)
`ifdef FA_PIPE_OVF_EN
    , .ovf(r8_ovf)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends one beat into an empty main pipe; returns cycles until out_valid (-1 on timeout).
  task automatic send_one(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                          output int lat);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    cin = tc;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, lat1, lat8, sent, recv, stall;
    bit          stall_done;
    logic [31:0] held_sum;
    logic        held_cout;
    logic [32:0] exp33;
    logic [8:0]  exp9;
    logic [32:0] q3[$];
    logic [8:0]  q1[$];
    logic [8:0]  q8[$];
    logic [31:0] va[4] = '{32'd1, 32'd3, 32'hFFFF0000, 32'd0};
    logic [31:0] vb[4] = '{32'd2, 32'd4, 32'h0000FFFF, 32'd0};
    logic        vc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] es[4] = '{32'd3, 32'd7, 32'h00000000, 32'd0};
    logic        ec[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = 32'd0; b = 32'd0; cin = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b1; s_a = 8'd0; s_b = 8'd0; s_cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 32'd0);
    check("rst_cout", cout, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_s1_out_valid", r1_out_valid, 1'b0);
    check("rst_s8_out_valid", r8_out_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Wrap-around with carry out, latency 4
    send_one(32'hFFFFFFFF, 32'h00000001, 1'b0, lat);
    check("t1_latency", lat, 4);
    check("t1_sum", sum, 32'h00000000);
    check("t1_cout", cout, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("t1_consumed", out_valid, 1'b0);

    // Four back-to-back beats emerge on four consecutive cycles
    for (int n = 0; n < 8; n++) begin
      if (n < 4) begin
        in_valid = 1'b1; a = va[n]; b = vb[n]; cin = vc[n];
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      check("t2_out_valid", out_valid, ((n + 1) >= 4) && ((n + 1) <= 7));
      if (((n + 1) >= 4) && ((n + 1) <= 7)) begin
        check("t2_sum", sum, es[n - 3]);
        check("t2_cout", cout, ec[n - 3]);
      end
    end

    // Streaming with a 6-cycle output stall
    sent = 0; recv = 0; stall = 0; stall_done = 1'b0;
    for (int cyc = 0; (cyc < 80) && (recv < 10); cyc++) begin
      if (out_valid && !stall_done) begin
        stall = 6; stall_done = 1'b1; held_sum = sum; held_cout = cout;
      end
      out_ready = (stall == 0);
      in_valid = (sent < 10);
      a = 32'h90000000 + 32'(sent);
      b = 32'h70000001 + 32'(sent);
      cin = sent[0];
      #1;
      if (stall > 0) begin
        check("t3_in_ready_stall", in_ready, 1'b0);
        check("t3_sum_held", sum, held_sum);
        check("t3_cout_held", cout, held_cout);
        stall--;
      end
      if (in_valid && in_ready) begin
        q3.push_back({1'b0, a} + {1'b0, b} + {32'd0, cin});
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q3.size() == 0) begin
          check("t3_spurious_beat", 1'b1, 1'b0);
        end else begin
          exp33 = q3.pop_front();
          check("t3_result", {cout, sum}, exp33);
        end
        recv++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("t3_sent", sent, 10);
    check("t3_recv", recv, 10);
    check("t3_stall_seen", stall_done, 1'b1);

    // Reset with beats in flight discards them
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'(i + 1); b = 32'h00000100; cin = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t4_rst_out_valid", out_valid, 1'b0);
    check("t4_rst_sum", sum, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("t4_no_ghost", out_valid, 1'b0);
    end
    send_one(32'd5, 32'd6, 1'b0, lat);
    check("t4_latency", lat, 4);
    check("t4_sum", sum, 32'h0000000B);
    @(posedge clk);
    @(negedge clk);

`ifdef FA_PIPE_OVF_EN
    send_one(32'h7FFFFFFF, 32'h00000001, 1'b0, lat);
    check("t5a_latency", lat, 4);
    check("t5a_sum", sum, 32'h80000000);
    check("t5a_ovf", ovf, 1'b1);
    check("t5a_cout", cout, 1'b0);
    @(posedge clk);
    @(negedge clk);
    send_one(32'h80000000, 32'h80000000, 1'b0, lat);
    check("t5b_sum", sum, 32'h00000000);
    check("t5b_ovf", ovf, 1'b1);
    check("t5b_cout", cout, 1'b1);
    @(posedge clk);
    @(negedge clk);
    send_one(32'h00000001, 32'h00000002, 1'b0, lat);
    check("t5c_ovf", ovf, 1'b0);
    @(posedge clk);
    @(negedge clk);
`endif

    // Latency of the 8/1 and 8/8 builds
    s_in_valid = 1'b1; s_a = 8'h0F; s_b = 8'hF1; s_cin = 1'b1;
    lat1 = -1; lat8 = -1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      @(negedge clk);
      s_in_valid = 1'b0;
      if (r1_out_valid && (lat1 < 0)) begin
        lat1 = n;
        check("t6_s1_result", {r1_cout, r1_sum}, 9'h101);
      end
      if (r8_out_valid && (lat8 < 0)) begin
        lat8 = n;
        check("t6_s8_result", {r8_cout, r8_sum}, 9'h101);
      end
    end
    check("t6_s1_latency", lat1, 1);
    check("t6_s8_latency", lat8, 8);

    // Random beats with random backpressure against a + b + cin
    for (int cyc = 0; cyc < 1400; cyc++) begin
      s_in_valid = (cyc < 1300) && ($urandom_range(0, 3) != 0);
      s_a = 8'($urandom);
      s_b = 8'($urandom);
      s_cin = 1'($urandom);
      s_out_ready = (cyc >= 1300) || ($urandom_range(0, 2) != 0);
      #1;
      exp9 = {1'b0, s_a} + {1'b0, s_b} + {8'd0, s_cin};
      if (s_in_valid && r1_in_ready) q1.push_back(exp9);
      if (s_in_valid && r8_in_ready) q8.push_back(exp9);
      if (r1_out_valid && s_out_ready) begin
        if (q1.size() == 0) check("t6_s1_spurious", 1'b1, 1'b0);
        else check("t6_s1_stream", {r1_cout, r1_sum}, q1.pop_front());
      end
      if (r8_out_valid && s_out_ready) begin
        if (q8.size() == 0) check("t6_s8_spurious", 1'b1, 1'b0);
        else check("t6_s8_stream", {r8_cout, r8_sum}, q8.pop_front());
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("t6_s1_drained", q1.size(), 0);
    check("t6_s8_drained", q8.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
